mem_port_arbiter: RTL and testbench

// Shares one single-ported unified memory between the pipeline IF stage (instruction fetch) and MEM stage (lw/sw).

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Memory port arbiter bus bundle.
// Groups the IF, MEM-stage, RAM and stall signals of the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ifReq;
    logic [ADDR_W-1:0] ifAddr;
    logic              ifAck;
    logic [DATA_W-1:0] ifRdata;

    logic              dReq;
    logic              dWe;
    logic [ADDR_W-1:0] dAddr;
    logic [DATA_W-1:0] dWdata;
    logic              dAck;
    logic [DATA_W-1:0] dRdata;

    logic              ramEn;
    logic              ramWe;
    logic [ADDR_W-1:0] ramAddr;
    logic [DATA_W-1:0] ramWdata;
    logic              ramReady;
    logic [DATA_W-1:0] ramRdata;

    logic              stallIF;
    logic              stallMEM;

    modport slave (
        input  ifReq, ifAddr,
        input  dReq, dWe, dAddr, dWdata,
        input  ramReady, ramRdata,
        output ifAck, ifRdata,
        output dAck, dRdata,
        output ramEn, ramWe, ramAddr, ramWdata,
        output stallIF, stallMEM
    );

    modport master (
        output ifReq, ifAddr,
        output dReq, dWe, dAddr, dWdata,
        output ramReady, ramRdata,
        input  ifAck, ifRdata,
        input  dAck, dRdata,
        input  ramEn, ramWe, ramAddr, ramWdata,
        input  stallIF, stallMEM
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and MEM stage.
// Data wins ties; a streak counter bounds how long fetch can starve.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4
) (
    input logic clk,
    input logic rst_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } owner_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    state_t            state;
    state_t            state_nxt;
    owner_t            owner;
    owner_t            owner_nxt;
    logic [3:0]        streak;
    logic [3:0]        streak_nxt;
    logic              grant;

    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] if_rdata;
    logic [DATA_W-1:0] d_rdata;

    // State, owner and starvation counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= OWN_NONE;
            streak <= 4'd0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            streak <= streak_nxt;
        end
    end

    // Next state, arbitration and streak update; requests only matter in IDLE
    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        streak_nxt = streak;
        grant      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.dReq && (!bus.ifReq || streak < STREAK_MAX)) begin
                    grant      = 1'b1;
                    owner_nxt  = OWN_D;
                    streak_nxt = bus.ifReq ? streak + 4'd1 : 4'd0;
                    state_nxt  = ISSUE;
                end else if (bus.ifReq) begin
                    grant      = 1'b1;
                    owner_nxt  = OWN_IF;
                    streak_nxt = 4'd0;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.ramReady) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                owner_nxt = OWN_NONE;
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture the winning request so the RAM sees stable fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (state == IDLE && grant) begin
            if (owner_nxt == OWN_D) begin
                lat_we    <= bus.dWe;
                lat_addr  <= bus.dAddr;
                lat_wdata <= bus.dWdata;
            end else begin
                lat_we    <= 1'b0;
                lat_addr  <= bus.ifAddr;
                lat_wdata <= '0;
            end
        end
    end

    // Return read data to its owner; stores leave dRdata alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata <= '0;
            d_rdata  <= '0;
        end else if (state == WAIT && bus.ramReady) begin
            if (owner == OWN_IF) begin
                if_rdata <= bus.ramRdata;
            end else if (owner == OWN_D && !lat_we) begin
                d_rdata <= bus.ramRdata;
            end
        end
    end

    assign bus.ramEn    = (state == ISSUE);
    assign bus.ramWe    = (state == ISSUE) && lat_we;
    assign bus.ramAddr  = lat_addr;
    assign bus.ramWdata = lat_wdata;

    assign bus.ifAck    = (state == DONE) && (owner == OWN_IF);
    assign bus.dAck     = (state == DONE) && (owner == OWN_D);
    assign bus.ifRdata  = if_rdata;
    assign bus.dRdata   = d_rdata;

    assign bus.stallIF  = bus.ifReq && !bus.ifAck;
    assign bus.stallMEM = bus.dReq && !bus.dAck;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// Stimulus queues expected RAM issues and acks; a monitor compares.
module tb_mem_port_arbiter;
    logic clk;
    logic rst_n;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .MAX_STREAK(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } ram_exp_t;

    ram_exp_t    exp_ram[$];
    logic [31:0] exp_if[$];
    logic [31:0] exp_d[$];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          rdy_cyc = -10;
    int          en_cyc = -10;
    bit          gap_chk = 0;
    bit          gap_first = 1;
    int          rd_delay = 1;
    logic [31:0] rd_val = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_ram(input logic [31:0] a, input logic we,
                            input logic [31:0] wd);
        ram_exp_t e;
        e.addr  = a;
        e.we    = we;
        e.wdata = wd;
        exp_ram.push_back(e);
    endtask

    // RAM model: answers each ramEn after rd_delay cycles
    initial begin
        bus.ramReady = 1'b0;
        bus.ramRdata = '0;
        forever begin
            @(negedge clk);
            if (bus.ramEn) begin
                @(posedge clk);
                repeat (rd_delay - 1) @(posedge clk);
                #1;
                bus.ramReady = 1'b1;
                bus.ramRdata = rd_val;
                @(posedge clk);
                #1;
                bus.ramReady = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents an event
    always @(negedge clk) begin
        ram_exp_t e;
        cyc++;
        if (rst_n) begin
            chk("stallIF", 32'(bus.stallIF), 32'(bus.ifReq & ~bus.ifAck));
            chk("stallMEM", 32'(bus.stallMEM), 32'(bus.dReq & ~bus.dAck));
            if (bus.ifAck && bus.dAck) begin
                chk("dual_ack", 32'd1, 32'd0);
            end
            if (bus.ramEn) begin
                if (exp_ram.size() == 0) begin
                    chk("unexpected_ramEn", 32'd1, 32'd0);
                end else begin
                    e = exp_ram.pop_front();
                    chk("ramAddr", bus.ramAddr, e.addr);
                    chk("ramWe", 32'(bus.ramWe), 32'(e.we));
                    if (e.we) chk("ramWdata", bus.ramWdata, e.wdata);
                end
                if (gap_chk && !gap_first) begin
                    chk("ramEn_gap", 32'(cyc - en_cyc), 32'd4);
                end
                gap_first = 0;
                en_cyc = cyc;
            end
            if (bus.ifAck) begin
                if (exp_if.size() == 0) begin
                    chk("unexpected_ifAck", 32'd1, 32'd0);
                end else begin
                    chk("ifRdata", bus.ifRdata, exp_if.pop_front());
                end
                chk("if_latency", 32'(cyc - rdy_cyc), 32'd1);
            end
            if (bus.dAck) begin
                if (exp_d.size() == 0) begin
                    chk("unexpected_dAck", 32'd1, 32'd0);
                end else begin
                    chk("dRdata", bus.dRdata, exp_d.pop_front());
                end
                chk("d_latency", 32'(cyc - rdy_cyc), 32'd1);
            end
            if (bus.ramReady) rdy_cyc = cyc;
        end
    end

    // Hold ifReq across n completed fetches, bounded
    task automatic drive_if(input logic [31:0] a, input int n);
        int k = 0;
        int t = 0;
        bus.ifAddr = a;
        bus.ifReq  = 1'b1;
        while (k < n && t < 200) begin
            @(negedge clk);
            t++;
            if (bus.ifAck) k++;
        end
        bus.ifReq = 1'b0;
        if (k < n) chk("if_timeout", 32'(k), 32'(n));
    endtask

    // Hold dReq across n completed data accesses, bounded
    task automatic drive_d(input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input int n);
        int k = 0;
        int t = 0;
        bus.dWe    = we;
        bus.dAddr  = a;
        bus.dWdata = wd;
        bus.dReq   = 1'b1;
        while (k < n && t < 200) begin
            @(negedge clk);
            t++;
            if (bus.dAck) k++;
        end
        bus.dReq = 1'b0;
        if (k < n) chk("d_timeout", 32'(k), 32'(n));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ramEn"}, 32'(bus.ramEn), 32'd0);
        chk({tag, "_ramWe"}, 32'(bus.ramWe), 32'd0);
        chk({tag, "_ramAddr"}, bus.ramAddr, 32'd0);
        chk({tag, "_ramWdata"}, bus.ramWdata, 32'd0);
        chk({tag, "_ifAck"}, 32'(bus.ifAck), 32'd0);
        chk({tag, "_dAck"}, 32'(bus.dAck), 32'd0);
        chk({tag, "_ifRdata"}, bus.ifRdata, 32'd0);
        chk({tag, "_dRdata"}, bus.dRdata, 32'd0);
    endtask

    initial begin
        int t;
        rst_n      = 1'b0;
        bus.ifReq  = 1'b0;
        bus.ifAddr = '0;
        bus.dReq   = 1'b0;
        bus.dWe    = 1'b0;
        bus.dAddr  = '0;
        bus.dWdata = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // IF only
        rd_delay = 1;
        rd_val   = 32'h2010_0005;
        push_ram(32'h0040_0000, 1'b0, 32'h0);
        exp_if.push_back(32'h2010_0005);
        drive_if(32'h0040_0000, 1);
        repeat (2) @(negedge clk);

        // Store then load
        rd_val = 32'hCAFE_0000;
        push_ram(32'h10, 1'b1, 32'hDEAD_BEEF);
        exp_d.push_back(32'h0);
        drive_d(1'b1, 32'h10, 32'hDEAD_BEEF, 1);
        repeat (2) @(negedge clk);
        rd_val = 32'hDEAD_BEEF;
        push_ram(32'h10, 1'b0, 32'h0);
        exp_d.push_back(32'hDEAD_BEEF);
        drive_d(1'b0, 32'h10, 32'h0, 1);
        repeat (2) @(negedge clk);

        // Both held: D,D,D,D,IF,D,D,D,D,IF
        rd_val = 32'h1234_5678;
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9) push_ram(32'h0000_0400, 1'b0, 32'h0);
            else push_ram(32'h0000_0100, 1'b0, 32'h0);
        end
        for (int i = 0; i < 8; i++) exp_d.push_back(32'h1234_5678);
        for (int i = 0; i < 2; i++) exp_if.push_back(32'h1234_5678);
        gap_chk   = 1;
        gap_first = 1;
        fork
            drive_d(1'b0, 32'h0000_0100, 32'h0, 8);
            drive_if(32'h0000_0400, 2);
        join
        gap_chk = 0;
        repeat (2) @(negedge clk);

        // Latency: ramReady 3 cycles after ramEn
        rd_delay = 3;
        rd_val   = 32'h0BAD_F00D;
        push_ram(32'h20, 1'b0, 32'h0);
        exp_d.push_back(32'h0BAD_F00D);
        drive_d(1'b0, 32'h20, 32'h0, 1);
        repeat (2) @(negedge clk);

        // Spurious ramReady in IDLE must not ack
        for (int i = 0; i < 2; i++) begin
            bus.ramReady = 1'b1;
            @(negedge clk);
            bus.ramReady = 1'b0;
            @(negedge clk);
            chk("spur_ifAck", 32'(bus.ifAck), 32'd0);
            chk("spur_dAck", 32'(bus.dAck), 32'd0);
        end

        // Reset in WAIT aborts the fetch
        rd_delay = 6;
        rd_val   = 32'h5555_AAAA;
        push_ram(32'h0040_0010, 1'b0, 32'h0);
        bus.ifAddr = 32'h0040_0010;
        bus.ifReq  = 1'b1;
        t = 0;
        while (!bus.ramEn && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.ramEn) chk("rst_ramEn_timeout", 32'd0, 32'd1);
        @(negedge clk);
        rst_n     = 1'b0;
        bus.ifReq = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk_all_zero("postrst");

        // Fresh fetch after reset
        rd_delay = 1;
        rd_val   = 32'h0000_1337;
        push_ram(32'h0040_0004, 1'b0, 32'h0);
        exp_if.push_back(32'h0000_1337);
        drive_if(32'h0040_0004, 1);

        // Back-to-back data with dReq held
        rd_val    = 32'h7777_0001;
        gap_chk   = 1;
        gap_first = 1;
        push_ram(32'h30, 1'b0, 32'h0);
        push_ram(32'h30, 1'b0, 32'h0);
        exp_d.push_back(32'h7777_0001);
        exp_d.push_back(32'h7777_0001);
        drive_d(1'b0, 32'h30, 32'h0, 2);
        gap_chk = 0;
        repeat (4) @(negedge clk);

        chk("left_ram", 32'(exp_ram.size()), 32'd0);
        chk("left_if", 32'(exp_if.size()), 32'd0);
        chk("left_d", 32'(exp_d.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
